// File: rtl/frame_cfg_pkg.sv
// Shared configuration-path definitions: FSM encodings, default broadcast
// address and the counter-width helper used by the config controller too.
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GUARD = 2'd2
    } frame_state_e;

    // All-ones address on the default 5-bit select bus selects every column.
    localparam int unsigned BROADCAST_SEL_DEFAULT = 31;

    // Number of bits needed to encode 'value' distinct values (ceil(log2)).
    function automatic int unsigned frame_clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_strobe_edge.sv
// Rising-edge detector for the controller's level FrameStrobe.
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset (previous-sample register -> 0)
//   strobe        level strobe input
//   strobe_edge_c combinational edge pulse: strobe & ~previous sample
// Because the history register resets low, a strobe that is already high
// when reset releases is reported as an edge on the first clock.
module frame_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic strobe_edge_c
);

    logic strobe_prev;

    // One-cycle history of the strobe level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_prev <= 1'b0;
        end else begin
            strobe_prev <= strobe;
        end
    end

    assign strobe_edge_c = strobe & ~strobe_prev;

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Registered per-column frame strobe sequencer.
// Captures FrameStrobe_I on a rising FrameStrobe edge addressed to this column
// (or broadcast), drives it on FrameStrobe_O for StrobeCycles clocks, then
// holds a GuardCycles idle gap before accepting another capture.
// Ports:
//   CLK, resetn     clock, asynchronous active-low reset
//   FrameStrobe_I   frame bits from the controller
//   FrameSelect     target column address
//   FrameStrobe     level strobe from the controller
//   OverrunClr      synchronous clear of Overrun
//   FrameStrobe_O   registered frame strobes to the column
//   Busy            high in PULSE or GUARD
//   Overrun         sticky: an addressed edge arrived while Busy
//   FrameCount      saturating count of accepted captures
module frame_strobe_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int unsigned MaxFramesPerCol  = 20,
    parameter int unsigned FrameSelectWidth = 5,
    parameter int unsigned Col              = 18,
    parameter int unsigned BroadcastSel     = BROADCAST_SEL_DEFAULT,
    parameter int unsigned StrobeCycles     = 1,
    parameter int unsigned GuardCycles      = 1,
    parameter int unsigned CntWidth         = 8
) (
    input  logic                        CLK,
    input  logic                        resetn,
    input  logic [MaxFramesPerCol-1:0]  FrameStrobe_I,
    input  logic [FrameSelectWidth-1:0] FrameSelect,
    input  logic                        FrameStrobe,
    input  logic                        OverrunClr,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe_O,
    output logic                        Busy,
    output logic                        Overrun,
    output logic [CntWidth-1:0]         FrameCount
);

    // Parameter legality.
    if (StrobeCycles < 1 || StrobeCycles > 255) begin : g_bad_strobe_cycles
        $error("frame_strobe_sequencer: StrobeCycles must be in 1..255");
    end
    if (GuardCycles > 255) begin : g_bad_guard_cycles
        $error("frame_strobe_sequencer: GuardCycles must be in 0..255");
    end
    if (Col >= (1 << FrameSelectWidth)) begin : g_bad_col
        $error("frame_strobe_sequencer: Col does not fit in FrameSelectWidth");
    end

    localparam int unsigned CNT_W = frame_clog2(256);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(StrobeCycles - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'((GuardCycles == 0) ? 0 : GuardCycles - 1);
    localparam bit               GUARD_EN    = (GuardCycles != 0);
    localparam logic [FrameSelectWidth-1:0] COL_SEL = FrameSelectWidth'(Col);
    localparam logic [FrameSelectWidth-1:0] BC_SEL  = FrameSelectWidth'(BroadcastSel);

    frame_state_e                state;
    logic [MaxFramesPerCol-1:0]  data_q;
    logic [MaxFramesPerCol-1:0]  strobe_q;
    logic [CNT_W-1:0]            cnt;
    logic                        busy_q;
    logic                        overrun_q;
    logic [CntWidth-1:0]         count_q;

    logic strobe_edge_c;
    logic hit_c;
    logic accept_c;
    logic overrun_evt_c;

    frame_strobe_edge u_edge (
        .clk           (CLK),
        .rst_n         (resetn),
        .strobe        (FrameStrobe),
        .strobe_edge_c (strobe_edge_c)
    );

    // Address match is only meaningful in the edge cycle.
    assign hit_c         = (FrameSelect == COL_SEL) | (FrameSelect == BC_SEL);
    assign accept_c      = strobe_edge_c & hit_c & (state == ST_IDLE);
    assign overrun_evt_c = strobe_edge_c & hit_c & (state != ST_IDLE);

    // Sequencer FSM with registered outputs.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            strobe_q  <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            count_q   <= '0;
        end else begin
            // Set beats clear when both happen in one cycle.
            if (overrun_evt_c) begin
                overrun_q <= 1'b1;
            end else if (OverrunClr) begin
                overrun_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    strobe_q <= '0;
                    if (accept_c) begin
                        data_q   <= FrameStrobe_I;
                        strobe_q <= FrameStrobe_I;
                        cnt      <= STROBE_LOAD;
                        busy_q   <= 1'b1;
                        state    <= ST_PULSE;
                        if (count_q != {CntWidth{1'b1}}) begin
                            count_q <= count_q + CntWidth'(1);
                        end
                    end
                end
                ST_PULSE: begin
                    strobe_q <= data_q;
                    if (cnt == '0) begin
                        strobe_q <= '0;
                        if (GUARD_EN) begin
                            cnt   <= GUARD_LOAD;
                            state <= ST_GUARD;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GUARD: begin
                    strobe_q <= '0;
                    if (cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    strobe_q <= '0;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign FrameStrobe_O = strobe_q;
    assign Busy          = busy_q;
    assign Overrun       = overrun_q;
    assign FrameCount    = count_q;

endmodule
